// File: rtl/rf_write_queue.sv
// Register-file write-back unit: merges execute writes and load returns onto one
// write port, queueing colliding loads in order and tracking pending load targets.
module rf_write_queue #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_we,
    input  logic                      ex_word,
    input  logic [ADDR_W-1:0]         ex_addr,
    input  logic [2*DATA_W-1:0]       ex_data,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      ld_ready,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [2*DATA_W-1:0]       rf_wdata,
    output logic                      rf_we_byte,
    output logic                      rf_we_word,
    input  logic [ADDR_W-1:0]         pend_addr,
    output logic                      pend_hit,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q;

    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [2*DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic                rf_we_byte_q, rf_we_byte_d;
    logic                rf_we_word_q, rf_we_word_d;

    logic empty, not_full, pop, bypass, ld_squash, push_req, push, drop;

    // A word write owns both registers of the even/odd pair.
    function automatic logic ex_hits(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] ea,
                                     input logic              word);
        if (word)
            return a[ADDR_W-1:1] == ea[ADDR_W-1:1];
        return a == ea;
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        not_full  = (count_q < CNT_W'(DEPTH));
        pop       = ~ex_we & ~empty;
        bypass    = ~ex_we & empty & ld_valid;
        ld_squash = ex_we & ld_valid & ex_hits(ld_addr, ex_addr, ex_word);
        push_req  = ld_valid & ~bypass & ~ld_squash;
        push      = push_req & (not_full | pop);
        drop      = push_req & ~push;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        valid_d = valid_q;
        if (ex_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ex_hits(addr_q[i], ex_addr, ex_word))
                    valid_d[i] = 1'b0;
            end
        end
        if (pop)
            valid_d[rd_ptr_q] = 1'b0;
        if (push)
            valid_d[wr_ptr_q] = 1'b1;
    end

    always_comb begin
        rf_we_byte_d = 1'b0;
        rf_we_word_d = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (ex_we) begin
            if (ex_word) begin
                rf_we_word_d = 1'b1;
                rf_waddr_d   = {ex_addr[ADDR_W-1:1], 1'b0};
                rf_wdata_d   = ex_data;
            end else begin
                rf_we_byte_d = 1'b1;
                rf_waddr_d   = ex_addr;
                rf_wdata_d   = {{DATA_W{1'b0}}, ex_data[DATA_W-1:0]};
            end
        end else if (pop) begin
            // A squashed head still pops, but produces no write.
            if (valid_q[rd_ptr_q]) begin
                rf_we_byte_d = 1'b1;
                rf_waddr_d   = addr_q[rd_ptr_q];
                rf_wdata_d   = {{DATA_W{1'b0}}, data_q[rd_ptr_q]};
            end
        end else if (bypass) begin
            rf_we_byte_d = 1'b1;
            rf_waddr_d   = ld_addr;
            rf_wdata_d   = {{DATA_W{1'b0}}, ld_data};
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == pend_addr))
                pend_hit = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_we_byte_q <= 1'b0;
            rf_we_word_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            count_q      <= count_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_we_byte_q <= rf_we_byte_d;
            rf_we_word_q <= rf_we_word_d;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    // NOTE: payload storage has no reset; the valid bits and count alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= ld_addr;
            data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign ld_ready   = not_full | (~empty & ~ex_we);
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign rf_we_byte = rf_we_byte_q;
    assign rf_we_word = rf_we_word_q;
    assign q_count    = count_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: directed vector table, hand sequences for
// overflow/wrap/reset, and random traffic against a queue-based reference model.
module tb_rf_write_queue;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_we = 1'b0, ex_word = 1'b0;
    logic [4:0]  ex_addr = '0;
    logic [15:0] ex_data = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic [4:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_we_byte, rf_we_word;
    logic [4:0]  pend_addr = '0;
    logic        pend_hit;
    logic [2:0]  q_count;
    logic        ovf_err;

    rf_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_we(ex_we), .ex_word(ex_word), .ex_addr(ex_addr), .ex_data(ex_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we_byte(rf_we_byte), .rf_we_word(rf_we_word),
        .pend_addr(pend_addr), .pend_hit(pend_hit), .q_count(q_count), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ex_we, ex_word;
        logic [4:0]  ex_addr;
        logic [15:0] ex_data;
        logic        ld_valid;
        logic [4:0]  ld_addr;
        logic [7:0]  ld_data;
        logic [4:0]  pend_addr;
        logic        exp_pend, exp_byte, exp_word;
        logic [4:0]  exp_waddr;
        logic [15:0] exp_wdata;
        logic [2:0]  exp_count;
    } vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        bit         valid;
    } entry_t;

    entry_t      mq[$];
    bit          m_ovf;
    logic        e_byte, e_word;
    logic [4:0]  e_waddr;
    logic [15:0] e_wdata;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        tab[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic we, input logic word, input logic [4:0] ea,
                                input logic [15:0] ed, input logic lv, input logic [4:0] la,
                                input logic [7:0] ld, input logic [4:0] pa);
        vec_t v;
        v.ex_we = we; v.ex_word = word; v.ex_addr = ea; v.ex_data = ed;
        v.ld_valid = lv; v.ld_addr = la; v.ld_data = ld; v.pend_addr = pa;
        v.exp_pend = 0; v.exp_byte = 0; v.exp_word = 0;
        v.exp_waddr = '0; v.exp_wdata = '0; v.exp_count = '0;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t v, input logic p, input logic b, input logic w,
                                      input logic [4:0] wa, input logic [15:0] wd, input logic [2:0] c);
        vec_t r = v;
        r.exp_pend = p; r.exp_byte = b; r.exp_word = w;
        r.exp_waddr = wa; r.exp_wdata = wd; r.exp_count = c;
        return r;
    endfunction

    // An execute write claims one register, or both registers of an even/odd pair.
    function automatic bit hits(input logic [4:0] a, input vec_t v);
        if (v.ex_word) return (a / 2) == (v.ex_addr / 2);
        return a == v.ex_addr;
    endfunction

    task automatic model_step(input vec_t v);
        entry_t head;
        bit bypassed;
        bypassed = 0;
        e_byte = 0; e_word = 0; e_waddr = '0; e_wdata = '0;
        if (v.ex_we) begin
            e_word  = v.ex_word;
            e_byte  = !v.ex_word;
            e_waddr = v.ex_word ? v.ex_addr - (v.ex_addr % 2) : v.ex_addr;
            e_wdata = v.ex_word ? v.ex_data : v.ex_data % 256;
            foreach (mq[i]) if (hits(mq[i].addr, v)) mq[i].valid = 0;
        end else if (mq.size() > 0) begin
            head = mq.pop_front();
            if (head.valid) begin
                e_byte = 1; e_waddr = head.addr; e_wdata = 16'(head.data);
            end
        end else if (v.ld_valid) begin
            bypassed = 1; e_byte = 1; e_waddr = v.ld_addr; e_wdata = 16'(v.ld_data);
        end
        if (v.ld_valid && !bypassed && !(v.ex_we && hits(v.ld_addr, v))) begin
            if (mq.size() < DEPTH) mq.push_back('{v.ld_addr, v.ld_data, 1'b1});
            else m_ovf = 1;
        end
    endtask

    task automatic do_cycle(input vec_t v, input bit tab_chk);
        bit m_ready, m_pend;
        @(negedge clk);
        ex_we = v.ex_we; ex_word = v.ex_word; ex_addr = v.ex_addr; ex_data = v.ex_data;
        ld_valid = v.ld_valid; ld_addr = v.ld_addr; ld_data = v.ld_data; pend_addr = v.pend_addr;
        #1;
        m_ready = (mq.size() < DEPTH) || (mq.size() > 0 && !v.ex_we);
        m_pend = 0;
        foreach (mq[i]) if (mq[i].valid && mq[i].addr == v.pend_addr) m_pend = 1;
        check("ld_ready", ld_ready, m_ready);
        check("pend_hit", pend_hit, m_pend);
        if (tab_chk) check("tab_pend_hit", pend_hit, v.exp_pend);
        model_step(v);
        @(posedge clk);
        #1;
        check("rf_we_byte", rf_we_byte, e_byte);
        check("rf_we_word", rf_we_word, e_word);
        if (e_byte || e_word) begin
            check("rf_waddr", rf_waddr, e_waddr);
            check("rf_wdata", rf_wdata, e_wdata);
        end
        check("q_count", q_count, mq.size());
        check("ovf_err", ovf_err, m_ovf);
        if (tab_chk) begin
            check("tab_we_byte", rf_we_byte, v.exp_byte);
            check("tab_we_word", rf_we_word, v.exp_word);
            if (v.exp_byte || v.exp_word) begin
                check("tab_waddr", rf_waddr, v.exp_waddr);
                check("tab_wdata", rf_wdata, v.exp_wdata);
            end
            check("tab_count", q_count, v.exp_count);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        ex_we = 0; ex_word = 0; ld_valid = 0;
        #1;
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_we_byte", rf_we_byte, 0);
        check("rst_we_word", rf_we_word, 0);
        check("rst_q_count", q_count, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_pend_hit", pend_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_ovf = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        tab[0] = with_exp(mk(1, 0, 16, 16'h00A5, 0, 0, 0, 0),         0, 1, 0, 16, 16'h00A5, 0);
        tab[1] = with_exp(mk(1, 1, 27, 16'h1234, 0, 0, 0, 0),         0, 0, 1, 26, 16'h1234, 0);
        tab[2] = with_exp(mk(1, 0, 9, 16'h0077, 1, 5, 8'h3C, 5),      0, 1, 0, 9, 16'h0077, 1);
        tab[3] = with_exp(mk(0, 0, 0, 0, 0, 0, 0, 5),                 1, 1, 0, 5, 16'h003C, 0);
        tab[4] = with_exp(mk(0, 0, 0, 0, 1, 3, 8'h11, 5),             0, 1, 0, 3, 16'h0011, 0);
        tab[5] = with_exp(mk(1, 0, 1, 16'h0001, 1, 24, 8'h55, 24),    0, 1, 0, 1, 16'h0001, 1);
        tab[6] = with_exp(mk(1, 1, 24, 16'hBEEF, 0, 0, 0, 24),        1, 0, 1, 24, 16'hBEEF, 1);
        tab[7] = with_exp(mk(0, 0, 0, 0, 0, 0, 0, 24),                0, 0, 0, 0, 0, 0);
        tab[8] = with_exp(mk(1, 0, 7, 16'h3C42, 1, 7, 8'h99, 7),      0, 1, 0, 7, 16'h0042, 0);
        tab[9] = with_exp(mk(0, 0, 0, 0, 0, 0, 0, 7),                 0, 0, 0, 0, 0, 0);

        reset_dut();
        for (int i = 0; i < 10; i++) do_cycle(tab[i], 1);

        // Sustained execute writes with a load every cycle: fill, then drop two.
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                @(negedge clk);
                ex_we = 1; ld_valid = 1;
                #1;
                check("full_ld_ready", ld_ready, 0);
            end
            do_cycle(mk(1, 0, 0, 16'(i), 1, 5'(10 + i), 8'(8'h80 + i), 0), 0);
        end
        check("ovf_q_count", q_count, 4);
        check("ovf_set", ovf_err, 1);
        for (int k = 0; k < 4; k++) begin
            do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
            check("drain_order", rf_waddr, 10 + k);
            check("drain_data", rf_wdata, 16'(8'h80 + k));
        end
        check("drain_empty", q_count, 0);

        // Full queue, no execute write, new load: simultaneous pop and push, pointers wrap.
        reset_dut();
        for (int i = 0; i < 4; i++) do_cycle(mk(1, 0, 0, 0, 1, 5'(10 + i), 8'(i), 0), 0);
        do_cycle(mk(0, 0, 0, 0, 1, 20, 8'hEE, 20), 0);
        check("wrap_count", q_count, 4);
        check("wrap_ovf", ovf_err, 0);
        check("wrap_pop_addr", rf_waddr, 10);
        for (int k = 0; k < 4; k++) begin
            do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 20), 0);
            check("wrap_drain", rf_waddr, (k == 3) ? 20 : 11 + k);
        end

        // Reset with three queued entries, then the first load is bypassed.
        reset_dut();
        for (int i = 0; i < 3; i++) do_cycle(mk(1, 0, 0, 0, 1, 5'(10 + i), 8'(i), 10), 0);
        reset_dut();
        do_cycle(mk(0, 0, 0, 0, 1, 6, 8'h21, 10), 0);
        check("post_rst_bypass_addr", rf_waddr, 6);
        check("post_rst_bypass_count", q_count, 0);

        // Random traffic on a narrow address range to provoke squashes and hazards.
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = mk($urandom_range(0, 99) < 55, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                   16'($urandom), $urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)),
                   8'($urandom), 5'($urandom_range(0, 7)));
            do_cycle(v, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
